instruction_fetch: RTL and testbench

- Upstream stage of control_matrix: fetches the 26-bit instruction addressed by control_matrix's 16-bit instructionPointer from byte-wide instruction memory.
- Assembles four byte beats into one instruction word and holds it for control_matrix behind a valid/ready handshake.
- Supports flush (jump redirect), memory wait states, a wait-state timeout and an illegal-padding flag.

---
 rtl/softcpu_pkg.sv | 25 ++
 rtl/fetch_timeout_counter.sv | 28 ++
 rtl/instruction_fetch.sv | 117 +++++++++++
 tb/tb_instruction_fetch.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softcpu_pkg.sv
// Shared soft-CPU definitions: instruction geometry, fetch FSM states and the
// opcode field position that control_matrix decodes.
package softcpu_pkg;

  localparam int INSTR_WIDTH     = 26;
  localparam int IP_WIDTH        = 16;
  localparam int BYTES_PER_INSTR = 4;
  localparam int BEAT_WIDTH      = $clog2(BYTES_PER_INSTR);
  localparam int WORD_WIDTH      = 8 * BYTES_PER_INSTR;
  localparam int OPCODE_MSB      = 25;
  localparam int OPCODE_LSB      = 22;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } fetch_state_t;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcodeOf(
    input logic [INSTR_WIDTH-1:0] instr
  );
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive cycles a fetch beat waits for the memory; flags expiry
// once the wait reaches TIMEOUT_CYCLES-1.
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  logic [7:0] r_waitCnt;

  assign o_expired = (r_waitCnt == 8'(TIMEOUT_CYCLES - 1));

  // Saturates at the expiry value so a stalled caller never wraps the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_waitCnt <= '0;
    end else if (i_clear) begin
      r_waitCnt <= '0;
    end else if (i_inc && !o_expired) begin
      r_waitCnt <= r_waitCnt + 8'd1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetches one instruction as four little-endian byte beats from byte-wide
// memory and holds it for control_matrix behind a valid/ready handshake.
module instruction_fetch
  import softcpu_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 18,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [IP_WIDTH-1:0]       instructionPointer,
  input  logic                      fetchEn,
  input  logic                      flush,
  output logic [MEM_ADDR_WIDTH-1:0] memAddress,
  output logic                      memRead,
  input  logic [7:0]                memData,
  input  logic                      memReady,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic                      instrValid,
  input  logic                      instrReady,
  output logic                      instrIllegal,
  output logic                      busError
);

  fetch_state_t          r_state;
  logic [IP_WIDTH-1:0]   r_pc;
  logic [BEAT_WIDTH-1:0] r_beat;
  logic [WORD_WIDTH-1:0] r_buffer;
  logic [WORD_WIDTH-1:0] w_assembled;
  logic                  w_expired;
  logic                  w_cntClear;
  logic                  w_cntInc;

  assign memRead    = (r_state == FETCH);
  assign memAddress = MEM_ADDR_WIDTH'({r_pc, r_beat});

  assign w_cntClear = flush || (r_state != FETCH) || memReady;
  assign w_cntInc   = (r_state == FETCH) && !memReady;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_clear  (w_cntClear),
    .i_inc    (w_cntInc),
    .o_expired(w_expired)
  );

  // Buffer with the current beat's byte merged in; on the last beat this is the full word.
  always_comb begin
    w_assembled                 = r_buffer;
    w_assembled[8*r_beat +: 8]  = memData;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_beat       <= '0;
      r_buffer     <= '0;
      instruction  <= '0;
      instrValid   <= 1'b0;
      instrIllegal <= 1'b0;
      busError     <= 1'b0;
    end else begin
      busError <= 1'b0;
      if (flush) begin
        r_state    <= IDLE;
        r_beat     <= '0;
        r_buffer   <= '0;
        instrValid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (fetchEn) begin
              r_pc    <= instructionPointer;
              r_beat  <= '0;
              r_state <= FETCH;
            end
          end
          FETCH: begin
            // A beat completing in the expiry cycle still counts as success.
            if (memReady) begin
              r_buffer <= w_assembled;
              r_beat   <= r_beat + 1'b1;
              if (r_beat == BEAT_WIDTH'(BYTES_PER_INSTR - 1)) begin
                r_state      <= HOLD;
                instrValid   <= 1'b1;
                instruction  <= w_assembled[INSTR_WIDTH-1:0];
                instrIllegal <= |w_assembled[WORD_WIDTH-1:INSTR_WIDTH];
              end
            end else if (w_expired) begin
              busError <= 1'b1;
              r_beat   <= '0;
              r_state  <= IDLE;
            end
          end
          HOLD: begin
            if (instrReady) begin
              instrValid <= 1'b0;
              if (fetchEn) begin
                r_pc    <= instructionPointer;
                r_beat  <= '0;
                r_state <= FETCH;
              end else begin
                r_state <= IDLE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a byte-array memory model answers
// reads, and expected words are rebuilt from that array per fetched address.
module tb_instruction_fetch;

  logic        clock;
  logic        reset_n;
  logic [15:0] instructionPointer;
  logic        fetchEn;
  logic        flush;
  logic [17:0] memAddress;
  logic        memRead;
  logic [7:0]  memData;
  logic        memReady;
  logic [25:0] instruction;
  logic        instrValid;
  logic        instrReady;
  logic        instrIllegal;
  logic        busError;

  int total = 0;
  int bad   = 0;

  logic [7:0] memBytes [0:1023];
  int readyMode = 0;
  int lowRun    = 0;

  instruction_fetch #(
    .MEM_ADDR_WIDTH(18),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .instructionPointer(instructionPointer),
    .fetchEn           (fetchEn),
    .flush             (flush),
    .memAddress        (memAddress),
    .memRead           (memRead),
    .memData           (memData),
    .memReady          (memReady),
    .instruction       (instruction),
    .instrValid        (instrValid),
    .instrReady        (instrReady),
    .instrIllegal      (instrIllegal),
    .busError          (busError)
  );

  assign memData = memBytes[memAddress[9:0]];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory word at word address ip, bytes stored little-endian.
  function automatic logic [31:0] refWord(input int ip);
    return {memBytes[4*ip+3], memBytes[4*ip+2], memBytes[4*ip+1], memBytes[4*ip]};
  endfunction

  // One clock: choose memReady (1=always, 2=never, 3=random with short stalls, 0=leave), then sample 1ns after the edge.
  task automatic step();
    if (readyMode == 1) memReady = 1'b1;
    else if (readyMode == 2) memReady = 1'b0;
    else if (readyMode == 3) begin
      if (lowRun >= 3) memReady = 1'b1;
      else memReady = ($urandom_range(0, 1) == 1);
      lowRun = memReady ? 0 : lowRun + 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic startFetch(input int ip);
    instructionPointer = 16'(ip);
    fetchEn = 1'b1;
    step();
    fetchEn = 1'b0;
  endtask

  task automatic waitValid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (instrValid) seen = 1'b1;
    end
  endtask

  task automatic consume();
    instrReady = 1'b1;
    step();
    instrReady = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    total++;
    if ({instrValid, instrIllegal, busError, memRead} !== 4'b0 || instruction !== 26'd0 || memAddress !== 18'd0) begin
      bad++;
      $display("[TB] FAIL reset_values: got valid=%b ill=%b berr=%b rd=%b instr=%h addr=%h want all zero",
               instrValid, instrIllegal, busError, memRead, instruction, memAddress);
    end
    @(posedge clock);
    #6;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_zero_wait();
    memBytes[0] = 8'h91; memBytes[1] = 8'hE1; memBytes[2] = 8'h44; memBytes[3] = 8'h00;
    readyMode = 1;
    startFetch(0);
    for (int b = 0; b < 4; b++) begin
      total++;
      if (memRead !== 1'b1 || memAddress !== 18'(b) || instrValid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL zw_beat%0d: got rd=%b addr=%0d valid=%b want rd=1 addr=%0d valid=0",
                 b, memRead, memAddress, instrValid, b);
      end
      step();
    end
    total++;
    if (instrValid !== 1'b1 || instruction !== 26'h044E191 || instrIllegal !== 1'b0 || memRead !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zw_result: got valid=%b instr=%h ill=%b rd=%b want valid=1 instr=044e191 ill=0 rd=0",
               instrValid, instruction, instrIllegal, memRead);
    end
  endtask

  task automatic test_hold();
    logic [31:0] w;
    bit seen;
    instrReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      instructionPointer = 16'($urandom_range(0, 255));
      step();
      total++;
      if (instrValid !== 1'b1 || instruction !== 26'h044E191) begin
        bad++;
        $display("[TB] FAIL hold_stable%0d: got valid=%b instr=%h want valid=1 instr=044e191",
                 i, instrValid, instruction);
      end
    end
    instructionPointer = 16'd6;
    fetchEn = 1'b1;
    instrReady = 1'b1;
    step();
    fetchEn = 1'b0;
    instrReady = 1'b0;
    total++;
    if (memRead !== 1'b1 || memAddress !== 18'd24 || instrValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_restart: got rd=%b addr=%0d valid=%b want rd=1 addr=24 valid=0",
               memRead, memAddress, instrValid);
    end
    waitValid(20, seen);
    w = refWord(6);
    total++;
    if (!seen || instruction !== w[25:0] || instrIllegal !== (w[31:26] != 6'd0)) begin
      bad++;
      $display("[TB] FAIL b2b_word6: got seen=%b instr=%h ill=%b want seen=1 instr=%h ill=%b",
               seen, instruction, instrIllegal, w[25:0], (w[31:26] != 6'd0));
    end
    consume();
    total++;
    if (instrValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL consume6: got valid=%b want 0", instrValid);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] w;
    readyMode = 0;
    memReady = 1'b0;
    startFetch(5);
    for (int k = 0; k < 12; k++) begin
      memReady = ((k % 3) == 2);
      total++;
      if (memRead !== 1'b1 || memAddress !== 18'(20 + k / 3) || busError !== 1'b0) begin
        bad++;
        $display("[TB] FAIL ws_cycle%0d: got rd=%b addr=%0d berr=%b want rd=1 addr=%0d berr=0",
                 k, memRead, memAddress, busError, 20 + k / 3);
      end
      step();
    end
    memReady = 1'b0;
    w = refWord(5);
    total++;
    if (instrValid !== 1'b1 || instruction !== w[25:0] || busError !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ws_result: got valid=%b instr=%h berr=%b want valid=1 instr=%h berr=0",
               instrValid, instruction, busError, w[25:0]);
    end
    consume();
  endtask

  task automatic test_flush();
    logic [31:0] w;
    bit seen;
    readyMode = 1;
    startFetch(3);
    step();
    step();
    total++;
    if (memAddress !== 18'd14) begin
      bad++;
      $display("[TB] FAIL flush_pre_addr: got %0d want 14", memAddress);
    end
    flush = 1'b1;
    fetchEn = 1'b1;
    instructionPointer = 16'd3;
    step();
    flush = 1'b0;
    fetchEn = 1'b0;
    total++;
    if (memRead !== 1'b0 || instrValid !== 1'b0 || busError !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_idle: got rd=%b valid=%b berr=%b want 0 0 0", memRead, instrValid, busError);
    end
    step();
    total++;
    if (memRead !== 1'b0 || instrValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_fetchen_ignored: got rd=%b valid=%b want 0 0", memRead, instrValid);
    end
    readyMode = 3;
    startFetch(7);
    waitValid(100, seen);
    w = refWord(7);
    total++;
    if (!seen || instruction !== w[25:0] || instrIllegal !== (w[31:26] != 6'd0)) begin
      bad++;
      $display("[TB] FAIL flush_refetch7: got seen=%b instr=%h ill=%b want seen=1 instr=%h ill=%b",
               seen, instruction, instrIllegal, w[25:0], (w[31:26] != 6'd0));
    end
    consume();
  endtask

  task automatic test_timeout();
    readyMode = 2;
    startFetch(9);
    for (int i = 1; i <= 14; i++) begin
      step();
      total++;
      if (busError !== 1'b0 || memRead !== 1'b1) begin
        bad++;
        $display("[TB] FAIL to_wait%0d: got berr=%b rd=%b want berr=0 rd=1", i, busError, memRead);
      end
    end
    step();
    total++;
    if (busError !== 1'b1 || memRead !== 1'b0 || instrValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL to_pulse: got berr=%b rd=%b valid=%b want berr=1 rd=0 valid=0",
               busError, memRead, instrValid);
    end
    step();
    total++;
    if (busError !== 1'b0 || memRead !== 1'b0) begin
      bad++;
      $display("[TB] FAIL to_after: got berr=%b rd=%b want berr=0 rd=0", busError, memRead);
    end
  endtask

  task automatic test_padding();
    logic [31:0] w;
    bit seen;
    memBytes[43] = 8'hFC;
    readyMode = 3;
    startFetch(10);
    waitValid(100, seen);
    w = refWord(10);
    total++;
    if (!seen || instrIllegal !== 1'b1 || instruction !== w[25:0]) begin
      bad++;
      $display("[TB] FAIL pad_illegal: got seen=%b ill=%b instr=%h want seen=1 ill=1 instr=%h",
               seen, instrIllegal, instruction, w[25:0]);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int ips [4];
    int n = 0;
    int cyc = 0;
    int lastCyc = 0;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) ips[i] = $urandom_range(20, 200);
    readyMode = 1;
    instructionPointer = 16'(ips[0]);
    fetchEn = 1'b1;
    instrReady = 1'b1;
    step();
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      cyc++;
      if (instrValid) begin
        w = refWord(ips[n]);
        total++;
        if (instruction !== w[25:0] || (n == 0 && cyc != 4) || (n > 0 && cyc - lastCyc != 5)) begin
          bad++;
          $display("[TB] FAIL b2b_item%0d: got instr=%h at cycle %0d (prev %0d) want instr=%h spacing 5 first at 4",
                   n, instruction, cyc, lastCyc, w[25:0]);
        end
        lastCyc = cyc;
        n++;
        if (n < 4) instructionPointer = 16'(ips[n]);
        else fetchEn = 1'b0;
      end
    end
    fetchEn = 1'b0;
    step();
    instrReady = 1'b0;
    total++;
    if (n != 4 || memRead !== 1'b0 || instrValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_count: got items=%0d rd=%b valid=%b want items=4 rd=0 valid=0", n, memRead, instrValid);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    bit seen;
    int ip;
    readyMode = 3;
    for (int t = 0; t < 8; t++) begin
      ip = $urandom_range(0, 255);
      startFetch(ip);
      waitValid(150, seen);
      w = refWord(ip);
      for (int h = 0; h <= int'($urandom_range(0, 3)); h++) begin
        if (h > 0) step();
        total++;
        if (!seen || instrValid !== 1'b1 || instruction !== w[25:0] || instrIllegal !== (w[31:26] != 6'd0)) begin
          bad++;
          $display("[TB] FAIL rnd%0d_ip%0d: got seen=%b valid=%b instr=%h ill=%b want valid=1 instr=%h ill=%b",
                   t, ip, seen, instrValid, instruction, instrIllegal, w[25:0], (w[31:26] != 6'd0));
        end
      end
      consume();
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    readyMode = 1;
    startFetch(11);
    waitValid(20, seen);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (!seen || instrValid !== 1'b0 || instruction !== 26'd0 || memRead !== 1'b0 || memAddress !== 18'd0) begin
      bad++;
      $display("[TB] FAIL reset_async: got seen=%b valid=%b instr=%h rd=%b addr=%0d want seen=1 and all zero",
               seen, instrValid, instruction, memRead, memAddress);
    end
    #2;
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    instructionPointer = '0;
    fetchEn = 1'b0;
    flush = 1'b0;
    memReady = 1'b0;
    instrReady = 1'b0;
    for (int i = 0; i < 1024; i++) memBytes[i] = 8'($urandom);
    test_reset();
    test_zero_wait();
    test_hold();
    test_wait_states();
    test_flush();
    test_timeout();
    test_padding();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
